// File: rtl/fifo_pkg.sv
// fifo_pkg
// Constants shared by the FIFO blocks.
//   LEVEL_W   : width of the local occupancy count
//   POP_DEPTH : number of words the pop stage can hold locally
package fifo_pkg;

    localparam int LEVEL_W   = 2;
    localparam int POP_DEPTH = 2;

endpackage

// File: rtl/fifo_pop_stage_if.sv
// fifo_pop_stage_if
// Bundles the pop stage's controller-side and stream-side signals.
//   empty, ram_rd_data, pop_req_n : FIFO controller / RAM read port
//   flush                         : synchronous clear of the stage
//   data_out, data_valid, data_ready, level : downstream FWFT stream
// Modports:
//   master : the pop stage itself
//   slave  : the environment around it (controller, RAM, consumer)
interface fifo_pop_stage_if
    import fifo_pkg::*;
#(
    parameter int width = 8
);
    logic               empty;
    logic               pop_req_n;
    logic [width-1:0]   ram_rd_data;
    logic               flush;
    logic [width-1:0]   data_out;
    logic               data_valid;
    logic               data_ready;
    logic [LEVEL_W-1:0] level;

    modport master (
        input  empty, ram_rd_data, flush, data_ready,
        output pop_req_n, data_out, data_valid, level
    );

    modport slave (
        output empty, ram_rd_data, flush, data_ready,
        input  pop_req_n, data_out, data_valid, level
    );
endinterface

// File: rtl/fifo_pop_skid.sv
// fifo_pop_skid
// Two-entry head/skid register pair that keeps words in arrival order.
//   clk, rst    : clock, async active-high reset
//   load        : load_data arrives this cycle
//   take        : head word is consumed this cycle
//   clear       : drop both entries (wins over load/take)
//   load_data   : incoming word
//   head        : head word
//   head_v      : head holds a word
//   skid_v      : skid holds a word
module fifo_pop_skid #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic             clear,
    input  logic [width-1:0] load_data,
    output logic [width-1:0] head,
    output logic             head_v,
    output logic             skid_v
);
    logic [width-1:0] skid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head   <= '0;
            skid   <= '0;
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (clear) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (take) begin
            if (skid_v) begin
                // Skid advances; a returning word backfills the skid.
                head   <= skid;
                head_v <= 1'b1;
                skid_v <= load;
                if (load) skid <= load_data;
            end else begin
                head_v <= load;
                if (load) head <= load_data;
            end
        end else if (load) begin
            // Skid is never occupied while head is free, so a free head
            // implies the word belongs there. The pop rule keeps both
            // entries from being full when a word returns untaken.
            if (!head_v) begin
                head   <= load_data;
                head_v <= 1'b1;
            end else begin
                skid   <= load_data;
                skid_v <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_pop_stage.sv
// fifo_pop_stage
// Read-side companion of the single-clock FIFO controller. Issues pops,
// captures the registered RAM read data one cycle later and presents it
// as a first-word-fall-through stream from a 2-entry local buffer.
//   clk, rst : clock, async active-high reset
//   bus      : fifo_pop_stage_if master modport (controller, RAM, stream)
module fifo_pop_stage
    import fifo_pkg::*;
#(
    parameter int width = 8
) (
    input  logic          clk,
    input  logic          rst,
    fifo_pop_stage_if.master bus
);
    logic               inflight;
    logic               take;
    logic               pop;
    logic               head_v;
    logic               skid_v;
    logic [width-1:0]   head;
    logic [LEVEL_W-1:0] held;
    logic [LEVEL_W:0]   occ;

    assign take = head_v & bus.data_ready;
    assign held = {1'b0, head_v} + {1'b0, skid_v};

    // Occupancy after this cycle: words held plus the one returning,
    // minus the one leaving. take implies head_v, so this never wraps.
    assign occ = {1'b0, held} + {{LEVEL_W{1'b0}}, inflight} - {{LEVEL_W{1'b0}}, take};

    // rst is included so the pop request reads inactive during reset.
    assign pop = !rst && !bus.empty && !bus.flush && (occ < (LEVEL_W+1)'(POP_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= pop;
        end
    end

    fifo_pop_skid #(.width(width)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (inflight & ~bus.flush),
        .take      (take & ~bus.flush),
        .clear     (bus.flush),
        .load_data (bus.ram_rd_data),
        .head      (head),
        .head_v    (head_v),
        .skid_v    (skid_v)
    );

    assign bus.pop_req_n  = ~pop;
    assign bus.data_out   = head;
    assign bus.data_valid = head_v;
    assign bus.level      = held;
endmodule

// File: doc/fifo_pop_stage.md
# fifo_pop_stage

Read-side companion for the single-clock FIFO controller. It issues pops to the controller, captures the data returned one cycle later by the registered-read RAM, and presents it downstream as a first-word-fall-through valid/ready stream with a 2-entry local buffer. This sustains one word per cycle with no bubbles. It sits between the controller's `pop_req_n`/`empty` pair plus the RAM read port on one side, and the consuming datapath on the other.

## Interface
- `width`, 8: data word width in bits (1..256).
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous reset, active-high.
- `empty` in 1: FIFO controller empty flag.
- `pop_req_n` out 1: pop request to the controller, active-low.
- `ram_rd_data` in `width`: RAM read data, valid in the cycle after a pop.
- `flush` in 1: synchronous clear of local state, active-high.
- `data_out` out `width`: head word.
- `data_valid` out 1: `data_out` holds a valid word.
- `data_ready` in 1: downstream accepts the head word this cycle.
- `level` out 2: words currently held locally (0..2).

## Operation
- **State:**
  - `head` register with its valid bit.
  - `skid` register with its valid bit.
  - `inflight` bit: a pop was issued last cycle.
- **Derived signals:**
  - `take` = `data_valid & data_ready`.
  - `held` = `head_v + skid_v`.
- **Pop rule:** `pop_req_n` = 0 iff `!empty && !flush && (held + inflight - take) < 2`. It never pops while `empty` = 1.
- **Return path:** when `inflight` = 1, `ram_rd_data` is captured on the edge.
  - Goes to `head` if `head` is free or being taken and `skid` is empty.
  - Otherwise goes to `skid`.
- **Take with skid full:** `skid` moves to `head`. Any returning word goes to `skid`. Order is strictly preserved.
- **Take with no replacement:** `head_v` clears.
- **Flush:**
  - Clears `head_v`, `skid_v` and `inflight` on the edge.
  - The word returning in the flush cycle is discarded.
  - No pop is issued in the flush cycle.
- **Outputs:** `data_out` = `head` register; `data_valid` = `head_v`; `level` = `held`.
- **Overflow guard:** a capture with both registers full and no take cannot occur by construction. The bench asserts this.

## Timing
- **Reset values:**
  - `pop_req_n` = 1, `data_valid` = 0, `data_out` = 0, `level` = 0.
  - `head_v`, `skid_v` and `inflight` = 0.
- **Reset mid-operation:** any in-flight return is dropped.
- **Latency:** pop in cycle N, then RAM data in cycle N+1, then `data_valid` = 1 in cycle N+2. First-word latency from `empty` falling is 2 cycles.
- **Throughput:** with `data_ready` held at 1 and the FIFO non-empty, one word per cycle in steady state.
- **Combinational paths:**
  - `data_ready` to `pop_req_n`, and `empty` to `pop_req_n`. Both are documented and allowed.
  - No combinational path from `ram_rd_data` to any output.
- **Backpressure:** `data_ready` = 0 with `held` = 2 gives `pop_req_n` = 1, whatever `empty` is. `held` = 1 plus `inflight` = 1 also blocks a pop unless `take` = 1.
- **Simultaneous take and return:**
  - `level` is unchanged.
  - With `skid` valid, `skid` advances to `head` and the return lands in `skid`.
  - With `skid` empty, the return lands in `head`.
- **Flush with `data_ready` = 1:** flush wins. No word is counted as taken by the stage's state. `data_valid` is 0 in the next cycle.

## Structure
- Shared package `fifo_pkg`:
  - `level` width constant (2).
  - Local-buffer depth constant (2).
  - Shared across the FIFO blocks.
- Sub-module `fifo_pop_skid`:
  - 2-entry head/skid register pair.
  - Inputs: `load`, `take`, `clear`.
  - Outputs: `head`, `head_v`, `skid_v`.
- The top holds only `inflight`, the pop rule and the flush gating.
- Target size: 150–250 lines total.

## Test plan
- **Reset release, FIFO empty:** `empty` = 1 for 10 cycles, so `pop_req_n` = 1, `data_valid` = 0, `level` = 0 throughout.
- **Single word:** drop `empty` in cycle 0 for one word with `ram_rd_data` = 8'hA5 in cycle 1. Expect `pop_req_n` = 0 in cycle 0 only, then `data_valid` = 1 and `data_out` = 8'hA5 from cycle 2 until `data_ready`.
- **Streaming:** FIFO holds 0x01..0x10 with `data_ready` = 1. Expect 16 consecutive valid beats in order and no bubbles after the first.
- **Backpressure:**
  - Hold `data_ready` = 0 while the FIFO holds 5 words. Exactly 2 pops are issued, `level` = 2, and `pop_req_n` then stays 1.
  - Release `data_ready`. Order 1..5 is preserved and nothing is dropped or duplicated.
- **Flush with return in flight:** assert `flush` in the cycle a word returns. Expect `data_valid` = 0 and `level` = 0 next cycle, the returned word never appears, and popping resumes the cycle after `flush` deasserts.
- **Async reset mid-stream:** pulse `rst` while `level` = 2 and `inflight` = 1. Outputs go to their reset values immediately, and no data appears until new pops.
